// File: rtl/multi_toggle_div_if.sv
// rtl/multi_toggle_div_if.sv - control and waveform bundle for the multi-channel toggle divider
interface multi_toggle_div_if #(
  parameter int CH = 4,
  parameter int W  = 3
);
  logic [CH-1:0]   en;
  logic [CH*W-1:0] period;
  logic [CH-1:0]   sync_in;
  logic [CH-1:0]   out;
  logic [CH-1:0]   tick;

  modport master (
    output en, period, sync_in,
    input  out, tick
  );

  modport slave (
    input  en, period, sync_in,
    output out, tick
  );
endinterface

// File: rtl/multi_toggle_div.sv
// rtl/multi_toggle_div.sv - per-channel programmable toggle divider with resync trigger
module multi_toggle_div #(
  parameter int CH         = 4,
  parameter int W          = 3,
  parameter int DEF_PERIOD = 3,
  parameter int TRIG_EDGE  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_toggle_div_if.slave  bus
);

  logic [CH-1:0] sq;
  logic [CH-1:0] sqq;
  logic [CH-1:0] out_q;
  logic [CH-1:0] tick_q;
  logic [CH-1:0] trig;
  logic [CH-1:0] fire;
  logic [W-1:0]  cnt [CH];
  logic [W-1:0]  lim [CH];

  // trig and term are OR-ed so a coincident pair yields one toggle, never two
  always_comb begin
    trig = (TRIG_EDGE != 0) ? (sq & ~sqq) : sq;
    fire = '0;
    for (int i = 0; i < CH; i++) begin
      fire[i] = trig[i] | (cnt[i] == lim[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq     <= '0;
      sqq    <= '0;
      out_q  <= '0;
      tick_q <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
        lim[i] <= W'(DEF_PERIOD);
      end
    end else begin
      sq  <= bus.sync_in;
      sqq <= sq;
      for (int i = 0; i < CH; i++) begin
        // the limit is only reloaded at a wrap or while idle, so a mid-count
        // period change never reshapes the half-period in progress
        if (!bus.en[i]) begin
          cnt[i]    <= '0;
          lim[i]    <= bus.period[i*W +: W];
          tick_q[i] <= 1'b0;
        end else if (fire[i]) begin
          out_q[i]  <= ~out_q[i];
          tick_q[i] <= 1'b1;
          cnt[i]    <= '0;
          lim[i]    <= bus.period[i*W +: W];
        end else begin
          cnt[i]    <= cnt[i] + 1'b1;
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_multi_toggle_div.sv
// tb/tb_multi_toggle_div.sv - scoreboard bench for level- and edge-triggered divider instances
module tb_multi_toggle_div;
  localparam int CH = 4;
  localparam int W  = 3;

  typedef struct packed {
    int   cyc;
    logic val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ev_t  sbq [8][$];
  logic exp_lvl [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_toggle_div_if #(.CH(CH), .W(W)) if_l ();
  multi_toggle_div_if #(.CH(CH), .W(W)) if_e ();

  multi_toggle_div #(.CH(CH), .W(W), .DEF_PERIOD(3), .TRIG_EDGE(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(if_l)
  );
  multi_toggle_div #(.CH(CH), .W(W), .DEF_PERIOD(3), .TRIG_EDGE(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(if_e)
  );

  // monitor: every tick must match the oldest expected event of its queue
  always @(negedge clk) begin
    logic tk;
    logic ov;
    ev_t  ev;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        tk = (d == 1) ? if_e.tick[c] : if_l.tick[c];
        ov = (d == 1) ? if_e.out[c]  : if_l.out[c];
        if (tk) begin
          n_tests++;
          if (sbq[d*4+c].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_tick dut%0d ch%0d at edge %0d (no event expected)", d, c, cyc);
          end else begin
            ev = sbq[d*4+c].pop_front();
            if (ev.cyc != cyc || ev.val != ov) begin
              n_fail++;
              $display("FAIL toggle dut%0d ch%0d: got edge %0d out %0b, expected edge %0d out %0b",
                       d, c, cyc, ov, ev.cyc, ev.val);
            end
          end
        end
      end
    end
  end

  task automatic push(input int d, input int c, input int e);
    ev_t ev;
    exp_lvl[d*4+c] = ~exp_lvl[d*4+c];
    ev.cyc = e;
    ev.val = exp_lvl[d*4+c];
    sbq[d*4+c].push_back(ev);
  endtask

  task automatic push2(input int c, input int e);
    push(0, c, e);
    push(1, c, e);
  endtask

  task automatic push_all(input int e);
    for (int c = 0; c < CH; c++) push2(c, e);
  endtask

  task automatic clear_lvl();
    for (int q = 0; q < 8; q++) exp_lvl[q] = 1'b0;
  endtask

  task automatic check_empty(input string name);
    for (int q = 0; q < 8; q++) begin
      n_tests++;
      if (sbq[q].size() != 0) begin
        n_fail++;
        $display("FAIL %s_missing dut%0d ch%0d: %0d events never seen, first expected at edge %0d",
                 name, q / 4, q % 4, sbq[q].size(), sbq[q][0].cyc);
        sbq[q].delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic set_en(input logic [3:0] v);
    if_l.en = v;
    if_e.en = v;
  endtask

  task automatic set_per(input logic [11:0] v);
    if_l.period = v;
    if_e.period = v;
  endtask

  task automatic set_sync(input logic [3:0] v);
    if_l.sync_in = v;
    if_e.sync_in = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    set_en(4'h0);
    set_sync(4'h0);
    clear_lvl();
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int lv [4];
    lv[0] = 0; lv[1] = 1; lv[2] = 2; lv[3] = 7;
    clear_lvl();
    set_en(4'h0);
    set_per(12'h6DB);
    set_sync(4'h0);
    step(2);
    chk("reset_out_l",  if_l.out,  4'h0);
    chk("reset_tick_l", if_l.tick, 4'h0);
    chk("reset_out_e",  if_e.out,  4'h0);
    chk("reset_tick_e", if_e.tick, 4'h0);
    rst_n = 1'b1;
    step(2);

    // defaults: first toggle 3 edges after enable, then every 4
    t = cyc + 1;
    for (int i = 3; i <= 19; i += 4) push_all(t + i);
    set_en(4'hF);
    step(20);
    set_en(4'h0);
    step(2);
    check_empty("defaults");

    // per-channel periods 0,1,2,7 (7 is the counter maximum)
    do_reset();
    set_per({3'd7, 3'd2, 3'd1, 3'd0});
    step(1);
    t = cyc + 1;
    for (int c = 0; c < CH; c++)
      for (int e = t + lv[c]; e <= t + 15; e += lv[c] + 1) push2(c, e);
    set_en(4'hF);
    step(16);
    set_en(4'h0);
    step(2);
    check_empty("periods");

    // one-cycle pulse at cnt=1, then sync held 3 cycles; disable on term
    do_reset();
    set_per(12'h6DB);
    step(1);
    t = cyc + 1;
    push(0, 0, t + 1); push(0, 0, t + 5); push(0, 0, t + 9);
    push(0, 0, t + 11); push(0, 0, t + 12); push(0, 0, t + 13);
    push(1, 0, t + 1); push(1, 0, t + 5); push(1, 0, t + 9);
    push(1, 0, t + 11); push(1, 0, t + 15);
    set_en(4'h1);
    set_sync(4'hF);
    step(1);
    set_sync(4'h0);
    step(9);
    set_sync(4'hF);
    step(3);
    set_sync(4'h0);
    step(4);
    set_en(4'h0);
    step(2);
    check_empty("sync_pulse");

    // sync held 5 cycles, first trigger landing on cnt==lim
    do_reset();
    set_per(12'h6DB);
    step(1);
    t = cyc + 1;
    for (int e = 3; e <= 7; e++) push(0, 0, t + e);
    push(0, 0, t + 11); push(0, 0, t + 15);
    push(1, 0, t + 3); push(1, 0, t + 7); push(1, 0, t + 11); push(1, 0, t + 15);
    set_en(4'h1);
    step(2);
    set_sync(4'hF);
    step(5);
    set_sync(4'h0);
    step(9);
    set_en(4'h0);
    step(2);
    check_empty("sync_hold");

    // period 3 -> 1 at cnt=1, disable on term, re-enable from cnt=0
    do_reset();
    set_per(12'h6DB);
    step(1);
    t = cyc + 1;
    push_all(t + 3); push_all(t + 5); push_all(t + 7); push_all(t + 12);
    set_en(4'hF);
    step(1);
    set_per(12'h249);
    step(8);
    set_en(4'h0);
    step(2);
    set_en(4'hF);
    step(2);
    set_en(4'h0);
    step(2);
    check_empty("period_change");

    // async reset while out=1 and tick=1, then limit restarts at default
    do_reset();
    set_per(12'h000);
    step(1);
    t = cyc + 1;
    push_all(t);
    set_en(4'hF);
    step(1);
    chk("pre_reset_out_l",  if_l.out,  4'hF);
    chk("pre_reset_tick_l", if_l.tick, 4'hF);
    chk("pre_reset_out_e",  if_e.out,  4'hF);
    chk("pre_reset_tick_e", if_e.tick, 4'hF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_l",  if_l.out,  4'h0);
    chk("async_tick_l", if_l.tick, 4'h0);
    chk("async_out_e",  if_e.out,  4'h0);
    chk("async_tick_e", if_e.tick, 4'h0);
    clear_lvl();
    step(2);
    rst_n = 1'b1;
    t = cyc + 1;
    push_all(t + 3); push_all(t + 4); push_all(t + 5);
    step(6);
    set_en(4'h0);
    step(2);
    check_empty("async_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
